// File: rtl/fp_multiplier_seq.sv
// fp_multiplier_seq
//   Iterative floating-point multiplier (sign / EXP_W-bit biased exponent /
//   MANT_W-bit fraction with implicit leading 1). The significand product is
//   built one multiplier bit per clock with a right-shifting accumulator, then
//   normalised, range-checked and registered onto the outputs in one cycle.
//   The accumulator holds the upper half of the product; every low product bit
//   is shifted out, and only the last one is kept because normalisation can
//   reach exactly one bit below the upper half.
module fp_multiplier_seq #(
   parameter int EXP_W  = 6,
   parameter int MANT_W = 12,
   parameter int BIAS   = 31
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic              Start,
   input  logic              SignA,
   input  logic [EXP_W-1:0]  ExponentA,
   input  logic [MANT_W-1:0] MantissaA,
   input  logic              SignB,
   input  logic [EXP_W-1:0]  ExponentB,
   input  logic [MANT_W-1:0] MantissaB,
   output logic              Busy,
   output logic              Done,
   output logic              SignOut,
   output logic [EXP_W-1:0]  ExponentOut,
   output logic [MANT_W-1:0] MantissaOut,
   output logic              Overflow,
   output logic              Underflow
);

   localparam int SIG_W  = MANT_W + 1;          // significand width incl. hidden 1
   localparam int ESUM_W = EXP_W + 2;           // signed working exponent width
   localparam int CNT_W  = $clog2(SIG_W);

   localparam logic [CNT_W-1:0]         LAST_CNT = CNT_W'(MANT_W);
   localparam logic [ESUM_W-1:0]        BIAS_E   = ESUM_W'(BIAS);
   localparam logic signed [ESUM_W-1:0] EXP_MAX  = ESUM_W'((1 << EXP_W) - 1);
   localparam logic signed [ESUM_W-1:0] EXP_MIN  = ESUM_W'(1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MULT = 2'd1,
      NORM = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [SIG_W-1:0]    acc_q, acc_d;        // upper half of the running product
   logic                low_q, low_d;        // most recent bit shifted out of acc
   logic [SIG_W-1:0]    mcand_q, mcand_d;    // {1, MantissaA}
   logic [SIG_W-1:0]    mplier_q, mplier_d;  // {1, MantissaB}, consumed LSB first
   logic                sign_q, sign_d;
   logic [ESUM_W-1:0]   esum_q, esum_d;      // EA + EB - BIAS, two's complement
   logic                zero_q, zero_d;      // either operand encodes zero
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                sign_out_q, sign_out_d;
   logic [EXP_W-1:0]    exp_out_q, exp_out_d;
   logic [MANT_W-1:0]   mant_out_q, mant_out_d;
   logic                ovf_q, ovf_d;
   logic                unf_q, unf_d;

   logic [SIG_W:0]             step_sum_s;
   logic signed [ESUM_W-1:0]   exp_fin_s;
   logic [MANT_W-1:0]          mant_norm_s;

   // One shift-add step: add the multiplicand when the current multiplier bit is set.
   always_comb begin
      step_sum_s = {1'b0, acc_q};
      if (mplier_q[0]) begin
         step_sum_s = {1'b0, acc_q} + {1'b0, mcand_q};
      end else begin
         step_sum_s = {1'b0, acc_q};
      end
   end

   // Normalise the finished product: a carry into the top bit bumps the exponent.
   always_comb begin
      exp_fin_s   = esum_q;
      mant_norm_s = {MANT_W{1'b0}};
      if (acc_q[SIG_W-1]) begin
         mant_norm_s = acc_q[MANT_W-1:0];
         exp_fin_s   = esum_q + ESUM_W'(1);
      end else begin
         mant_norm_s = {acc_q[MANT_W-2:0], low_q};
         exp_fin_s   = esum_q;
      end
   end

   // Next-state and datapath control for the IDLE -> MULT -> NORM sequence.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      acc_d      = acc_q;
      low_d      = low_q;
      mcand_d    = mcand_q;
      mplier_d   = mplier_q;
      sign_d     = sign_q;
      esum_d     = esum_q;
      zero_d     = zero_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      sign_out_d = sign_out_q;
      exp_out_d  = exp_out_q;
      mant_out_d = mant_out_q;
      ovf_d      = ovf_q;
      unf_d      = unf_q;

      case (state_q)
         IDLE: begin
            if (Start) begin
               state_d  = MULT;
               busy_d   = 1'b1;
               cnt_d    = {CNT_W{1'b0}};
               acc_d    = {SIG_W{1'b0}};
               low_d    = 1'b0;
               mcand_d  = {1'b1, MantissaA};
               mplier_d = {1'b1, MantissaB};
               sign_d   = SignA ^ SignB;
               esum_d   = ESUM_W'(ExponentA) + ESUM_W'(ExponentB) - BIAS_E;
               zero_d   = (ExponentA == {EXP_W{1'b0}}) || (ExponentB == {EXP_W{1'b0}});
            end else begin
               busy_d = 1'b0;
            end
         end

         MULT: begin
            acc_d    = step_sum_s[SIG_W:1];
            low_d    = step_sum_s[0];
            mplier_d = {1'b0, mplier_q[SIG_W-1:1]};
            if (cnt_q == LAST_CNT) begin
               state_d = NORM;
               cnt_d   = {CNT_W{1'b0}};
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         NORM: begin
            state_d    = IDLE;
            busy_d     = 1'b0;
            done_d     = 1'b1;
            sign_out_d = sign_q;
            if (zero_q) begin
               exp_out_d  = {EXP_W{1'b0}};
               mant_out_d = {MANT_W{1'b0}};
               ovf_d      = 1'b0;
               unf_d      = 1'b0;
            end else if (exp_fin_s > EXP_MAX) begin
               exp_out_d  = {EXP_W{1'b1}};
               mant_out_d = {MANT_W{1'b1}};
               ovf_d      = 1'b1;
               unf_d      = 1'b0;
            end else if (exp_fin_s < EXP_MIN) begin
               exp_out_d  = {EXP_W{1'b0}};
               mant_out_d = {MANT_W{1'b0}};
               ovf_d      = 1'b0;
               unf_d      = 1'b1;
            end else begin
               exp_out_d  = exp_fin_s[EXP_W-1:0];
               mant_out_d = mant_norm_s;
               ovf_d      = 1'b0;
               unf_d      = 1'b0;
            end
         end

         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
            cnt_d   = {CNT_W{1'b0}};
         end
      endcase
   end

   // State, datapath and output registers; reset aborts any operation in flight.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state_q    <= IDLE;
         cnt_q      <= {CNT_W{1'b0}};
         acc_q      <= {SIG_W{1'b0}};
         low_q      <= 1'b0;
         mcand_q    <= {SIG_W{1'b0}};
         mplier_q   <= {SIG_W{1'b0}};
         sign_q     <= 1'b0;
         esum_q     <= {ESUM_W{1'b0}};
         zero_q     <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         sign_out_q <= 1'b0;
         exp_out_q  <= {EXP_W{1'b0}};
         mant_out_q <= {MANT_W{1'b0}};
         ovf_q      <= 1'b0;
         unf_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         acc_q      <= acc_d;
         low_q      <= low_d;
         mcand_q    <= mcand_d;
         mplier_q   <= mplier_d;
         sign_q     <= sign_d;
         esum_q     <= esum_d;
         zero_q     <= zero_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         sign_out_q <= sign_out_d;
         exp_out_q  <= exp_out_d;
         mant_out_q <= mant_out_d;
         ovf_q      <= ovf_d;
         unf_q      <= unf_d;
      end
   end

   assign Busy        = busy_q;
   assign Done        = done_q;
   assign SignOut     = sign_out_q;
   assign ExponentOut = exp_out_q;
   assign MantissaOut = mant_out_q;
   assign Overflow    = ovf_q;
   assign Underflow   = unf_q;

endmodule
